// File: rtl/ram_ctrl_pkg.sv
// Shared types for the single_ram request controller: FSM state encoding and
// the request record queued between the request port and the RAM sequencer.
package ram_ctrl_pkg;

   localparam int unsigned REQ_ADDR_W = 10;
   localparam int unsigned REQ_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      CAPTURE
   } ram_state_t;

   typedef struct packed {
      logic                  write;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
   } ram_req_t;

   localparam int unsigned REQ_W = $bits(ram_req_t);

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO with a registered full flag; push and pop may
// coincide at any occupancy, including full.
module req_fifo #(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request-side controller for single_ram: queues requests, sequences the RAM
// control pins, owns the bidirectional data bus and returns read data.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_chip_select,
   output logic                  ram_write_enable,
   output logic                  ram_output_enable
);

   localparam int unsigned RW = 1 + ADDR_WIDTH + DATA_WIDTH;

   ram_state_t                  state;
   logic [DATA_WIDTH-1:0]       wdata_q;
   logic                        push;
   logic                        pop;
   logic [RW-1:0]               head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        head_write;
   logic [ADDR_WIDTH-1:0]       head_addr;
   logic [DATA_WIDTH-1:0]       head_wdata;

   req_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({req_write, req_addr, req_wdata}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign req_ready  = !fifo_full;
   assign push       = req_valid && req_ready;
   assign head_write = head[RW-1];
   assign head_addr  = head[RW-2 -: ADDR_WIDTH];
   assign head_wdata = head[DATA_WIDTH-1:0];
   assign busy       = (fifo_count != '0) || (state != IDLE);

   // READ is the only state that must not hand over to the next request.
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty && (state != READ)) pop = 1'b1;
   end

   assign ram_data = (state == WRITE) ? wdata_q : 'z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         ram_addr          <= '0;
         wdata_q           <= '0;
         ram_chip_select   <= 1'b0;
         ram_write_enable  <= 1'b0;
         ram_output_enable <= 1'b0;
         rsp_valid         <= 1'b0;
         rsp_rdata         <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == CAPTURE) begin
            rsp_rdata <= ram_data;
            rsp_valid <= 1'b1;
         end
         if (pop) begin
            ram_addr        <= head_addr;
            wdata_q         <= head_wdata;
            ram_chip_select <= 1'b1;
            if (head_write) begin
               state             <= WRITE;
               ram_write_enable  <= 1'b1;
               ram_output_enable <= 1'b0;
            end else begin
               state             <= READ;
               ram_write_enable  <= 1'b0;
               ram_output_enable <= 1'b1;
            end
         end else if (state == READ) begin
            state <= CAPTURE;
         end else begin
            state             <= IDLE;
            ram_chip_select   <= 1'b0;
            ram_write_enable  <= 1'b0;
            ram_output_enable <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request-side controller for the `single_ram` array. It buffers read/write requests in a small FIFO and sequences the RAM's `chip_select`, `write_enable` and `output_enable` pins. It owns the bidirectional data bus and returns read data on a one-cycle response strobe. It sits directly upstream of `single_ram` and is the only agent permitted to drive its pins.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, RAM address width.
- `DATA_WIDTH`, 8, RAM data width.
- `FIFO_DEPTH`, 4, request FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; high when not full.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse; read data valid.
- `rsp_rdata`  out  DATA_WIDTH  read data; holds its value until the next response.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `ram_addr`  out  ADDR_WIDTH  to `single_ram.addr`.
- `ram_data`  inout  DATA_WIDTH  to `single_ram.data`.
- `ram_chip_select`, `ram_write_enable`, `ram_output_enable`  out  1 each  to matching `single_ram` pins.

## Operation
- A request is accepted on any edge where `req_valid && req_ready`. The write flag, address and data are pushed as one FIFO entry.
- FSM states:
  - IDLE: all RAM controls 0.
  - WRITE: cs=1, we=1, oe=0.
  - READ: cs=1, we=0, oe=1.
  - CAPTURE: cs=1, we=0, oe=1.
- IDLE pops the FIFO head when the FIFO is non-empty. It goes to WRITE or READ according to the write flag.
- WRITE lasts exactly 1 cycle. The RAM latches the data at the edge that ends WRITE.
- READ → CAPTURE unconditionally.
- CAPTURE samples `ram_data` into `rsp_rdata` at its ending edge. `rsp_valid` is high for the following cycle.
- On leaving WRITE or CAPTURE:
  - If the FIFO is non-empty, pop and go directly to the next WRITE or READ. There is no IDLE bubble.
  - Otherwise go to IDLE.
- `ram_addr` and the internal write-data register are loaded on pop and held for the whole operation.
- `ram_data` is driven with the write data only while in WRITE; it is `'z` in every other state. The controller never drives the bus while `ram_output_enable` = 1.
- Simultaneous push and pop on one edge is legal at any occupancy, including full; the count is unchanged. A push while full is ignored, since `req_ready` = 0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is ADDR-independent, with width $clog2(FIFO_DEPTH)+1.
- Requests complete strictly in order; no reordering of reads around writes.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - `ram_addr`=0, all RAM controls 0, `ram_data`=`'z`.
- Reset asserted mid-operation aborts immediately and asynchronously. Pending FIFO entries are discarded and the RAM controls drop to 0 with no glitch to 1.
- Write latency: accept at edge E on an empty, idle block. Popped at E+1, WRITE during cycle E+1..E+2, RAM written at E+2.
- Read latency: accept at E. READ during E+1..E+2, CAPTURE E+2..E+3, sample at E+3, `rsp_valid` high during E+3..E+4.
- Throughput: 1 write per cycle, 1 read per 2 cycles when back-to-back.
- `req_ready` is a registered function of FIFO count. It is not combinationally dependent on `req_valid`.

## Structure
- Package `ram_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} ram_state_t`.
  - Packed request struct (`write`, `addr`, `wdata`) parameterised via localparam widths matching the defaults.
- Sub-module `req_fifo` holds the synchronous FIFO (push/pop/full/empty/count, async active-low reset). The FSM and bus tri-state stay in `ram_access_ctrl`.

## Test plan
- Reset mid-transaction: assert `rst_n`=0 during a WRITE → all RAM controls 0 and `ram_data`=z within the same cycle. FIFO is empty after release, `busy`=0.
- Sequential write/read: write addresses 0..15 with data 0xA0+i, then read 0..15 → 16 `rsp_valid` pulses, in order, with `rsp_rdata`=0xA0+i. Each read pulse arrives exactly 3 edges after its acceptance when the block is idle.
- Full FIFO: hold `req_valid`=1 with 6 reads while stalled → `req_ready` falls after 4 are accepted. No request is lost or duplicated, and the responses match the written data.
- Simultaneous push/pop at full: push on the pop edge → count stays 4 and the pointer wraps correctly. All 8 responses return in order.
- Write-after-read hazard: read addr 5 (=0x11), write addr 5 = 0x77, read addr 5 → responses are 0x11 then 0x77.
- Bus contention check: assert in the bench that the controller never drives `ram_data` while `ram_output_enable`=1 across all scenarios.
